pipe_if_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register of the 5-stage pipelined CPU; feeds the ID stage/control unit.

---
 rtl/pipe_if_stage.sv | 164 ++++++++++++++++
 tb/tb_pipe_if_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_if_stage
// Purpose  : Instruction fetch with a req/ack memory port, plus the IF/ID register.
// Revision : 1.0  initial release
// ============================================================================
module pipe_if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  pcsource,
   input  logic        flush,
   input  logic        wpcir,
   input  logic [31:0] bpc,
   input  logic [31:0] rpc,
   input  logic [31:0] jpc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] dpc4,
   output logic [31:0] dinst,
   output logic        dvalid
);

   typedef enum logic [1:0] {
      F_RESET = 2'd0,
      F_REQ   = 2'd1,
      F_HOLD  = 2'd2,
      F_KILL  = 2'd3
   } fstate_t;

   localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

   fstate_t     state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] ktgt_q, ktgt_d;
   logic [31:0] dpc4_q, dpc4_d;
   logic [31:0] dinst_q, dinst_d;
   logic        dvalid_q, dvalid_d;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_tgt_raw;
   logic [31:0] w_target;

   assign w_pc_plus4 = pc_q + 32'd4;

   always_comb begin
      w_tgt_raw = w_pc_plus4;
      case (pcsource)
         2'b01:   w_tgt_raw = bpc;
         2'b10:   w_tgt_raw = rpc;
         2'b11:   w_tgt_raw = jpc;
         default: w_tgt_raw = w_pc_plus4;
      endcase
   end

   assign w_target = w_tgt_raw & c_ALIGN_MASK;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      buf_d    = buf_q;
      ktgt_d   = ktgt_q;
      dpc4_d   = dpc4_q;
      dinst_d  = dinst_q;
      dvalid_d = dvalid_q;
      case (state_q)
         F_RESET: state_d = F_REQ;
         F_REQ: begin
            if (imem_ack) begin
               if (!wpcir) begin
                  // ID is stalled: park the word and stop fetching until it frees up.
                  buf_d   = imem_rdata;
                  state_d = F_HOLD;
               end else if (flush) begin
                  dpc4_d   = 32'd0;
                  dinst_d  = 32'd0;
                  dvalid_d = 1'b0;
                  pc_d     = w_target;
               end else begin
                  dpc4_d   = w_pc_plus4;
                  dinst_d  = imem_rdata;
                  dvalid_d = 1'b1;
                  pc_d     = w_pc_plus4;
               end
            end else if (wpcir) begin
               dpc4_d   = 32'd0;
               dinst_d  = 32'd0;
               dvalid_d = 1'b0;
               if (flush) begin
                  ktgt_d  = w_target;
                  state_d = F_KILL;
               end
            end
         end
         F_HOLD: begin
            if (wpcir) begin
               state_d = F_REQ;
               if (flush) begin
                  dpc4_d   = 32'd0;
                  dinst_d  = 32'd0;
                  dvalid_d = 1'b0;
                  buf_d    = 32'd0;
                  pc_d     = w_target;
               end else begin
                  dpc4_d   = w_pc_plus4;
                  dinst_d  = buf_q;
                  dvalid_d = 1'b1;
                  pc_d     = w_pc_plus4;
               end
            end
         end
         F_KILL: begin
            // The in-flight request must complete before the address may move.
            if (wpcir) begin
               dpc4_d   = 32'd0;
               dinst_d  = 32'd0;
               dvalid_d = 1'b0;
               if (flush) begin
                  ktgt_d = w_target;
               end
            end
            if (imem_ack) begin
               pc_d    = (wpcir && flush) ? w_target : ktgt_q;
               state_d = F_REQ;
            end
         end
         default: state_d = F_RESET;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= F_RESET;
         pc_q     <= RESET_PC & c_ALIGN_MASK;
         buf_q    <= 32'd0;
         ktgt_q   <= 32'd0;
         dpc4_q   <= 32'd0;
         dinst_q  <= 32'd0;
         dvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         buf_q    <= buf_d;
         ktgt_q   <= ktgt_d;
         dpc4_q   <= dpc4_d;
         dinst_q  <= dinst_d;
         dvalid_q <= dvalid_d;
      end
   end

   assign imem_req  = (state_q == F_REQ) || (state_q == F_KILL);
   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign dpc4      = dpc4_q;
   assign dinst     = dinst_q;
   assign dvalid    = dvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_if_stage
// Purpose  : Directed and random checks of pipe_if_stage against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_if_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  pcsource;
   logic        flush;
   logic        wpcir;
   logic [31:0] bpc, rpc, jpc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc, dpc4, dinst;
   logic        dvalid;

   int n_assert = 0;
   int n_fail   = 0;

   // Behavioural view: is fetch running, is a word parked, is a redirect waiting on an ack.
   bit          m_started, m_holding, m_killing;
   logic [31:0] m_pc, m_buf, m_ktgt, m_dpc4, m_dinst;
   logic        m_dvalid;

   pipe_if_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clock(clock), .reset(reset), .pcsource(pcsource), .flush(flush), .wpcir(wpcir),
      .bpc(bpc), .rpc(rpc), .jpc(jpc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .dpc4(dpc4),
      .dinst(dinst), .dvalid(dvalid)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] memw(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   assign imem_rdata = memw(imem_addr);

   function automatic logic [31:0] tgt_of(input logic [1:0] s, input logic [31:0] b,
                                          input logic [31:0] r, input logic [31:0] j);
      logic [31:0] t;
      t = (s == 2'd1) ? b : (s == 2'd2) ? r : j;
      return {t[31:2], 2'b00};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bubble();
      m_dpc4 = 32'd0; m_dinst = 32'd0; m_dvalid = 1'b0;
   endtask

   task automatic deliver(input logic [31:0] w);
      m_dpc4 = m_pc + 32'd4; m_dinst = w; m_dvalid = 1'b1; m_pc = m_pc + 32'd4;
   endtask

   task automatic model_update();
      logic [31:0] t;
      t = tgt_of(pcsource, bpc, rpc, jpc);
      if (reset) begin
         m_started = 0; m_holding = 0; m_killing = 0;
         m_pc = 32'd0; m_buf = 32'd0; m_ktgt = 32'd0;
         bubble();
      end else if (!m_started) begin
         m_started = 1;
      end else if (m_holding) begin
         if (wpcir) begin
            m_holding = 0;
            if (flush) begin bubble(); m_pc = t; end
            else deliver(m_buf);
         end
      end else if (m_killing) begin
         if (wpcir) begin
            bubble();
            if (flush) m_ktgt = t;
         end
         if (imem_ack) begin m_pc = m_ktgt; m_killing = 0; end
      end else if (imem_ack) begin
         if (!wpcir) begin m_buf = memw(m_pc); m_holding = 1; end
         else if (flush) begin bubble(); m_pc = t; end
         else deliver(memw(m_pc));
      end else if (wpcir) begin
         bubble();
         if (flush) begin m_ktgt = t; m_killing = 1; end
      end
   endtask

   task automatic check_model();
      chk("req",    {31'd0, imem_req}, {31'd0, m_started && !m_holding});
      chk("addr",   imem_addr, m_pc);
      chk("pc",     pc, m_pc);
      chk("dpc4",   dpc4, m_dpc4);
      chk("dinst",  dinst, m_dinst);
      chk("dvalid", {31'd0, dvalid}, {31'd0, m_dvalid});
   endtask

   task automatic step();
      @(posedge clock);
      model_update();
      @(negedge clock);
      check_model();
   endtask

   initial begin
      reset = 1'b1; pcsource = 2'd0; flush = 1'b0; wpcir = 1'b1;
      bpc = 32'd0; rpc = 32'd0; jpc = 32'd0; imem_ack = 1'b0;
      m_started = 0; m_holding = 0; m_killing = 0;
      m_pc = 0; m_buf = 0; m_ktgt = 0; m_dpc4 = 0; m_dinst = 0; m_dvalid = 0;
      @(negedge clock);
      step();
      step();
      chk("rst_req",    {31'd0, imem_req}, 32'd0);
      chk("rst_pc",     pc, 32'd0);
      chk("rst_dinst",  dinst, 32'd0);
      chk("rst_dvalid", {31'd0, dvalid}, 32'd0);
      chk("rst_dpc4",   dpc4, 32'd0);

      // Zero-wait fetch stream.
      reset = 1'b0; imem_ack = 1'b1;
      step();
      chk("t1_addr0", imem_addr, 32'd0);
      chk("t1_req",   {31'd0, imem_req}, 32'd1);
      step();
      chk("t1_instA", dinst, memw(32'd0));
      chk("t1_dpc4A", dpc4, 32'd4);
      chk("t1_addr4", imem_addr, 32'd4);
      step();
      chk("t1_instB", dinst, memw(32'd4));
      chk("t1_dpc4B", dpc4, 32'd8);

      // Slow memory at pc=8.
      imem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_addr",   imem_addr, 32'd8);
         chk("t2_dvalid", {31'd0, dvalid}, 32'd0);
      end
      imem_ack = 1'b1;
      step();
      chk("t2_inst", dinst, memw(32'd8));
      chk("t2_dpc4", dpc4, 32'd12);

      // ID stall while the word at 12 arrives.
      wpcir = 1'b0;
      step();
      chk("t3_req",  {31'd0, imem_req}, 32'd0);
      chk("t3_held", dinst, memw(32'd8));
      imem_ack = 1'b0;
      step();
      chk("t3_req2", {31'd0, imem_req}, 32'd0);
      wpcir = 1'b1;
      step();
      chk("t3_inst", dinst, memw(32'd12));
      chk("t3_addr", imem_addr, 32'd16);

      // Branch redirect with ack in the same cycle.
      imem_ack = 1'b1; flush = 1'b1; pcsource = 2'd1; bpc = 32'h40;
      step();
      chk("t4_bubble", {31'd0, dvalid}, 32'd0);
      chk("t4_addr",   imem_addr, 32'h40);
      flush = 1'b0; pcsource = 2'd0;
      step();
      chk("t4_inst", dinst, memw(32'h40));

      // jr redirect with the fetch still outstanding.
      imem_ack = 1'b0; flush = 1'b1; pcsource = 2'd2; rpc = 32'h103;
      step();
      chk("t5_addr_old", imem_addr, 32'h44);
      flush = 1'b0; pcsource = 2'd0;
      step();
      chk("t5_addr_old2", imem_addr, 32'h44);
      imem_ack = 1'b1;
      step();
      chk("t5_addr_new", imem_addr, 32'h100);
      chk("t5_drop",     {31'd0, dvalid}, 32'd0);
      step();
      chk("t5_inst", dinst, memw(32'h100));

      // Reset while a redirect waits on an ack.
      imem_ack = 1'b0; flush = 1'b1; pcsource = 2'd3; jpc = 32'h200;
      step();
      flush = 1'b0; pcsource = 2'd0; reset = 1'b1; imem_ack = 1'b1;
      step();
      chk("t6_req",    {31'd0, imem_req}, 32'd0);
      chk("t6_pc",     pc, 32'd0);
      chk("t6_dinst",  dinst, 32'd0);
      chk("t6_dvalid", {31'd0, dvalid}, 32'd0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 3000; i++) begin
         reset    = ($urandom_range(0, 199) == 0);
         wpcir    = ($urandom_range(0, 9) < 8);
         flush    = ($urandom_range(0, 4) == 0);
         pcsource = flush ? 2'($urandom_range(1, 3)) : 2'd0;
         bpc      = $urandom;
         rpc      = $urandom;
         jpc      = $urandom;
         imem_ack = ($urandom_range(0, 9) < 6);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
